// File: rtl/bop_range_sched.sv
// bop_range_sched: overflow-range table with round-robin insert, merge/evict, flush and registered lookup (BOP_SCHED_STATS_EN adds stats counters)
module bop_range_sched #(
  parameter int NUM_ENTRIES = 8,
  parameter int ADDR_W = 32,
  localparam int IDX_W = $clog2(NUM_ENTRIES)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [1:0]          req_valid_i,
  output logic [1:0]          req_ready_o,
  input  logic [2*ADDR_W-1:0] req_first_i,
  input  logic [2*ADDR_W-1:0] req_last_i,
  input  logic                flush_i,
  output logic                busy_o,
  input  logic                lookup_valid_i,
  input  logic [ADDR_W-1:0]   lookup_addr_i,
  output logic                hit_o,
  output logic                hit_first_o,
  output logic [IDX_W-1:0]    hit_idx_o,
`ifdef BOP_SCHED_STATS_EN
  output logic [15:0]         insert_cnt_o,
  output logic [15:0]         merge_cnt_o,
  output logic [15:0]         evict_cnt_o,
`endif
  output logic [IDX_W:0]      num_valid_o
);
  typedef enum logic [1:0] {IDLE, SCAN, COMMIT, FLUSH} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] first_q [NUM_ENTRIES];
  logic [ADDR_W-1:0] last_q [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] valid_q;
  logic [ADDR_W-1:0] cur_first_q, cur_last_q, rf, rl, m_first, m_last;
  logic [IDX_W-1:0] scan_idx_q, wr_ptr_q, flush_idx_q, match_idx_q, lk_idx;
  logic merge_q, rr_q, flush_pend_q, gnt, flush_req, accept, scan_hit, lk_hit;
  logic [ADDR_W:0] e_last_p1, cur_last_p1;
  logic [IDX_W:0] cnt;
  assign gnt = req_valid_i[rr_q] ? rr_q : ~rr_q;
  assign rf = gnt ? req_first_i[ADDR_W +: ADDR_W] : req_first_i[0 +: ADDR_W];
  assign rl = gnt ? req_last_i[ADDR_W +: ADDR_W] : req_last_i[0 +: ADDR_W];
  assign flush_req = flush_i || flush_pend_q;
  assign accept = (state_q == IDLE) && !flush_req && |req_valid_i;
  assign req_ready_o = accept ? (2'b01 << gnt) : 2'b00;
  assign busy_o = state_q != IDLE;
  assign num_valid_o = cnt;
  assign e_last_p1 = {1'b0, last_q[scan_idx_q]} + 1'b1;
  assign cur_last_p1 = {1'b0, cur_last_q} + 1'b1;
  assign scan_hit = valid_q[scan_idx_q] && ({1'b0, first_q[scan_idx_q]} <= cur_last_p1) &&
                    ({1'b0, cur_first_q} <= e_last_p1);
  assign m_first = (cur_first_q < first_q[match_idx_q]) ? cur_first_q : first_q[match_idx_q];
  assign m_last = (cur_last_q > last_q[match_idx_q]) ? cur_last_q : last_q[match_idx_q];
  // next-state: flush has priority in IDLE; pending flush follows COMMIT without returning to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = flush_req ? FLUSH : (accept && rf <= rl) ? SCAN : IDLE;
      SCAN:    state_d = (scan_hit || scan_idx_q == IDX_W'(NUM_ENTRIES-1)) ? COMMIT : SCAN;
      COMMIT:  state_d = flush_req ? FLUSH : IDLE;
      FLUSH:   state_d = (flush_idx_q == IDX_W'(NUM_ENTRIES-1)) ? IDLE : FLUSH;
      default: state_d = IDLE;
    endcase
  end
  // lookup against the current table; lowest index wins, plus valid-entry count
  always_comb begin
    lk_hit = 1'b0;
    lk_idx = '0;
    cnt = '0;
    for (int i = NUM_ENTRIES-1; i >= 0; i--) begin
      if (valid_q[i] && first_q[i] <= lookup_addr_i && lookup_addr_i <= last_q[i]) begin
        lk_hit = 1'b1;
        lk_idx = IDX_W'(i);
      end
      cnt = cnt + (IDX_W+1)'(valid_q[i]);
    end
  end
  // FSM, table and lookup registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      valid_q <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        first_q[i] <= '0;
        last_q[i] <= '0;
      end
      cur_first_q <= '0;
      cur_last_q <= '0;
      scan_idx_q <= '0;
      wr_ptr_q <= '0;
      flush_idx_q <= '0;
      match_idx_q <= '0;
      merge_q <= 1'b0;
      rr_q <= 1'b0;
      flush_pend_q <= 1'b0;
      hit_o <= 1'b0;
      hit_first_o <= 1'b0;
      hit_idx_o <= '0;
    end else begin
      state_q <= state_d;
      hit_o <= lookup_valid_i && lk_hit;
      hit_first_o <= lookup_valid_i && lk_hit && lookup_addr_i == first_q[lk_idx];
      hit_idx_o <= (lookup_valid_i && lk_hit) ? lk_idx : '0;
      flush_idx_q <= (state_q == FLUSH) ? flush_idx_q + 1'b1 : '0;
      if (flush_i && (state_q == SCAN || state_q == COMMIT)) flush_pend_q <= 1'b1;
      if (accept) begin
        rr_q <= ~gnt;
        cur_first_q <= rf;
        cur_last_q <= rl;
        scan_idx_q <= '0;
      end
      if (state_q == SCAN) begin
        merge_q <= scan_hit;
        match_idx_q <= scan_idx_q;
        scan_idx_q <= scan_idx_q + 1'b1;
      end
      if (state_q == COMMIT && merge_q) begin
        first_q[match_idx_q] <= m_first;
        last_q[match_idx_q] <= m_last;
      end
      if (state_q == COMMIT && !merge_q) begin
        first_q[wr_ptr_q] <= cur_first_q;
        last_q[wr_ptr_q] <= cur_last_q;
        valid_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (state_q == FLUSH) valid_q[flush_idx_q] <= 1'b0;
      if (state_q == FLUSH && flush_idx_q == IDX_W'(NUM_ENTRIES-1)) begin
        wr_ptr_q <= '0;
        flush_pend_q <= 1'b0;
      end
    end
  end
`ifdef BOP_SCHED_STATS_EN
  // saturating commit statistics, untouched by flush
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      insert_cnt_o <= '0;
      merge_cnt_o <= '0;
      evict_cnt_o <= '0;
    end else if (state_q == COMMIT) begin
      if (!merge_q && insert_cnt_o != 16'hFFFF) insert_cnt_o <= insert_cnt_o + 1'b1;
      if (merge_q && merge_cnt_o != 16'hFFFF) merge_cnt_o <= merge_cnt_o + 1'b1;
      if (!merge_q && valid_q[wr_ptr_q] && evict_cnt_o != 16'hFFFF) evict_cnt_o <= evict_cnt_o + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_bop_range_sched.sv
// tb_bop_range_sched: scoreboard bench for bop_range_sched (checks stats when BOP_SCHED_STATS_EN is defined)
module tb_bop_range_sched;
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic [1:0] req_valid = '0;
  logic [1:0] req_ready;
  logic [63:0] req_first = '0;
  logic [63:0] req_last = '0;
  logic flush = 1'b0;
  logic busy;
  logic lookup_valid = 1'b0;
  logic [31:0] lookup_addr = '0;
  logic hit, hit_first;
  logic [2:0] hit_idx;
  logic [3:0] num_valid;
`ifdef BOP_SCHED_STATS_EN
  logic [15:0] insert_cnt, merge_cnt, evict_cnt;
`endif
  int n_tests = 0;
  int n_fail = 0;
  typedef struct {logic hit; logic first; logic [2:0] idx; logic [31:0] addr;} exp_t;
  exp_t sb[$];
  int gq[$];

  bop_range_sched dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_first_i(req_first), .req_last_i(req_last), .flush_i(flush), .busy_o(busy),
    .lookup_valid_i(lookup_valid), .lookup_addr_i(lookup_addr), .hit_o(hit),
    .hit_first_o(hit_first), .hit_idx_o(hit_idx),
`ifdef BOP_SCHED_STATS_EN
    .insert_cnt_o(insert_cnt), .merge_cnt_o(merge_cnt), .evict_cnt_o(evict_cnt),
`endif
    .num_valid_o(num_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic insert(input int r, input logic [31:0] f, input logic [31:0] l);
    int n = 0;
    req_valid[r] = 1'b1;
    req_first[r*32 +: 32] = f;
    req_last[r*32 +: 32] = l;
    #1;
    while (!req_ready[r] && n < 100) begin
      tick();
      n++;
    end
    check("ready_wait", 64'(n < 100), 1);
    tick();
    req_valid[r] = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    check("idle_wait", 64'(n < 100), 1);
  endtask

  task automatic lookup(input logic [31:0] a, input logic eh, input logic ef, input logic [2:0] ei);
    exp_t e;
    sb.push_back('{eh, ef, ei, a});
    lookup_valid = 1'b1;
    lookup_addr = a;
    tick();
    lookup_valid = 1'b0;
    e = sb.pop_front();
    check($sformatf("hit@%0h", e.addr), hit, e.hit);
    check($sformatf("hit_first@%0h", e.addr), hit_first, e.first);
    check($sformatf("hit_idx@%0h", e.addr), hit_idx, e.idx);
  endtask

  initial begin
    int i0, i1, n, bc;
    logic [1:0] g;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_num_valid", num_valid, 0);
    check("rst_hit", {hit, hit_first, hit_idx}, 0);
    check("rst_ready", req_ready, 0);
    rst_ni = 1'b1;
    tick();
    // basic insert and inclusive lookups
    insert(0, 32'h1000, 32'h100F);
    check("busy_after_accept", busy, 1);
    wait_idle();
    check("nv_one", num_valid, 1);
    lookup(32'h100F, 1, 0, 0);
    lookup(32'h1010, 0, 0, 0);
    // adjacent range merges into entry 0
    insert(1, 32'h1010, 32'h101F);
    wait_idle();
    check("nv_merge", num_valid, 1);
    lookup(32'h101F, 1, 0, 0);
    lookup(32'h1000, 1, 1, 0);
    lookup_addr = 32'h1000;
    tick();
    check("strobe_low", {hit, hit_first, hit_idx}, 0);
    // both requesters held valid: grants must alternate
    gq = '{0, 1, 0, 1, 0, 1, 0, 1};
    i0 = 0;
    i1 = 0;
    n = 0;
    while ((i0 < 4 || i1 < 4) && n < 400) begin
      req_valid = {1'(i1 < 4), 1'(i0 < 4)};
      req_first[31:0] = 32'(32'h2000 + i0 * 256);
      req_last[31:0] = 32'(32'h200F + i0 * 256);
      req_first[63:32] = 32'(32'h3000 + i1 * 256);
      req_last[63:32] = 32'(32'h300F + i1 * 256);
      #1;
      g = req_ready;
      if (|g) check("rr_grant", g, (gq.size() > 0) ? 2'b01 << gq.pop_front() : 2'b00);
      tick();
      if (g[0]) i0++;
      if (g[1]) i1++;
      n++;
    end
    req_valid = '0;
    check("rr_no_starve", {1'(i1 == 4), 1'(i0 == 4)}, 2'b11);
    wait_idle();
    // ninth allocation evicted entry 0
    check("nv_full", num_valid, 8);
    lookup(32'h1000, 0, 0, 0);
    lookup(32'h3305, 1, 0, 0);
    lookup(32'h2100, 1, 1, 3);
    lookup(32'h2000, 1, 1, 1);
`ifdef BOP_SCHED_STATS_EN
    check("evict_cnt", evict_cnt, 1);
    check("merge_cnt", merge_cnt, 1);
    check("insert_cnt", insert_cnt, 9);
`endif
    // flush during SCAN: commit, then N flush cycles with busy held
    insert(0, 32'h5000, 32'h500F);
    check("scan_busy", busy, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bc = 1;
    while (busy && bc < 100) begin
      bc++;
      tick();
    end
    check("flush_busy_cycles", bc, 17);
    check("nv_flushed", num_valid, 0);
    lookup(32'h5000, 0, 0, 0);
    lookup(32'h3305, 0, 0, 0);
    // no merge across the top of the address space
    insert(0, 32'hFFFFFFF0, 32'hFFFFFFFF);
    wait_idle();
    insert(1, 32'h0, 32'hF);
    wait_idle();
    check("nv_nowrap", num_valid, 2);
    lookup(32'hFFFFFFFF, 1, 0, 0);
    lookup(32'h5, 1, 0, 1);
    lookup(32'h0, 1, 1, 1);
    // reversed range is accepted and dropped
    insert(1, 32'h20, 32'h10);
    check("discard_idle", busy, 0);
    check("nv_discard", num_valid, 2);
    lookup(32'h18, 0, 0, 0);
    // reset mid-SCAN clears everything
    insert(0, 32'h7000, 32'h700F);
    lookup_valid = 1'b1;
    lookup_addr = 32'hFFFFFFF8;
    tick();
    lookup_valid = 1'b0;
    check("pre_rst_hit", hit, 1);
    check("pre_rst_busy", busy, 1);
    rst_ni = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_nv", num_valid, 0);
    check("mid_rst_hit", {hit, hit_first, hit_idx}, 0);
    check("mid_rst_ready", req_ready, 0);
    tick();
    rst_ni = 1'b1;
    tick();
    lookup(32'hFFFFFFF8, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
